// File: rtl/sync_mon_pkg.sv
// Shared definitions for the synchronizer mismatch monitor.
//   state_e        : measurement FSM states
//   SEL_*          : byte_sel readout encodings
//   ID_BYTE        : fixed identification byte
package sync_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [2:0] SEL_MIS0   = 3'd0;
  localparam logic [2:0] SEL_MIS1   = 3'd1;
  localparam logic [2:0] SEL_MIS2   = 3'd2;
  localparam logic [2:0] SEL_EDGE0  = 3'd3;
  localparam logic [2:0] SEL_EDGE1  = 3'd4;
  localparam logic [2:0] SEL_EDGE2  = 3'd5;
  localparam logic [2:0] SEL_STATUS = 3'd6;
  localparam logic [2:0] SEL_ID     = 3'd7;

  localparam logic [7:0] ID_BYTE = 8'hA5;

endpackage

// File: rtl/sync_mismatch_monitor_sat_counter.sv
// Saturating up-counter with sticky saturation flag.
//   clk, rst : clock, synchronous active-high reset
//   clr      : clear count and flag (beats inc)
//   inc      : increment request
//   cnt      : current count
//   sat      : set when inc arrives while count is at all-ones
module sat_counter #(
  parameter int unsigned CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clr) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (inc) begin
      if (cnt_q == '1) sat_d = 1'b1;
      else             cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign cnt = cnt_q;
  assign sat = sat_q;

endmodule

// File: rtl/sync_mismatch_monitor.sv
// Compares a 1-flop synchronizer output against a reference synchronizer
// over a programmable window, counting disagreeing cycles and reference
// edges; results are read back one byte at a time.
//   clk, rst   : clock, synchronous active-high reset
//   fast_q     : short synchronizer output
//   ref_q      : reference synchronizer output
//   start      : begin a measurement from IDLE/DONE
//   win_sel    : window = WIN_BASE << (4*win_sel), sampled on start
//   byte_sel   : readout select (registered, 1-cycle latency)
//   count_byte : selected readout byte
//   busy/done  : measurement running / finished
//   sat        : a counter saturated in the current/last run
module sync_mismatch_monitor
  import sync_mon_pkg::*;
#(
  parameter int unsigned CNT_W     = 24,
  parameter int unsigned ALIGN_DLY = 2,
  parameter int unsigned WIN_BASE  = 1024,
  parameter int unsigned WIN_W     = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fast_q,
  input  logic       ref_q,
  input  logic       start,
  input  logic [1:0] win_sel,
  input  logic [2:0] byte_sel,
  output logic [7:0] count_byte,
  output logic       busy,
  output logic       done,
  output logic       sat
);

  localparam int unsigned EXT_W = (CNT_W > 24) ? CNT_W : 24;

  logic [ALIGN_DLY-1:0] dly_q, dly_d;
  logic                 mis_q, mis_d;
  logic                 ref_dly_q, ref_dly_d;
  logic                 edge_q, edge_d;
  state_e               state_q, state_d;
  logic [WIN_W-1:0]     win_q, win_d;
  logic [7:0]           count_byte_q, count_byte_d;

  logic                 clr, inc_mis, inc_edge;
  logic [CNT_W-1:0]     mis_cnt, edge_cnt;
  logic                 mis_sat, edge_sat;
  logic [EXT_W-1:0]     mis_ext, edge_ext;
  logic [WIN_W-1:0]     win_load;

  // Alignment pipeline runs regardless of state. The shift is written as a
  // widened concat then truncated so ALIGN_DLY=1 needs no special case.
  always_comb begin
    dly_d     = ALIGN_DLY'({dly_q, fast_q});
    mis_d     = dly_q[ALIGN_DLY-1] ^ ref_q;
    ref_dly_d = ref_q;
    edge_d    = ref_q ^ ref_dly_q;
  end

  assign win_load = WIN_W'(WIN_BASE) << {win_sel, 2'b00};

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    clr     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          win_d   = win_load;
          clr     = 1'b1;
        end
      end
      RUN: begin
        win_d = win_q - WIN_W'(1);
        if (win_q == WIN_W'(1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign inc_mis  = (state_q == RUN) && mis_q;
  assign inc_edge = (state_q == RUN) && edge_q;

  sat_counter #(.CNT_W(CNT_W)) u_mis_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (inc_mis),
    .cnt (mis_cnt),
    .sat (mis_sat)
  );

  sat_counter #(.CNT_W(CNT_W)) u_edge_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (inc_edge),
    .cnt (edge_cnt),
    .sat (edge_sat)
  );

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sat  = mis_sat | edge_sat;

  // Zero-extension makes bits above CNT_W read as 0.
  assign mis_ext  = EXT_W'(mis_cnt);
  assign edge_ext = EXT_W'(edge_cnt);

  always_comb begin
    count_byte_d = '0;
    case (byte_sel)
      SEL_MIS0:   count_byte_d = mis_ext[7:0];
      SEL_MIS1:   count_byte_d = mis_ext[15:8];
      SEL_MIS2:   count_byte_d = mis_ext[23:16];
      SEL_EDGE0:  count_byte_d = edge_ext[7:0];
      SEL_EDGE1:  count_byte_d = edge_ext[15:8];
      SEL_EDGE2:  count_byte_d = edge_ext[23:16];
      SEL_STATUS: count_byte_d = {5'b0, sat, done, busy};
      SEL_ID:     count_byte_d = ID_BYTE;
      default:    count_byte_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dly_q        <= '0;
      mis_q        <= 1'b0;
      ref_dly_q    <= 1'b0;
      edge_q       <= 1'b0;
      state_q      <= IDLE;
      win_q        <= '0;
      count_byte_q <= '0;
    end else begin
      dly_q        <= dly_d;
      mis_q        <= mis_d;
      ref_dly_q    <= ref_dly_d;
      edge_q       <= edge_d;
      state_q      <= state_d;
      win_q        <= win_d;
      count_byte_q <= count_byte_d;
    end
  end

  assign count_byte = count_byte_q;

endmodule

// File: tb/tb_sync_mismatch_monitor.sv
// Randomized bench for sync_mismatch_monitor. Two instances share stimulus:
// default 24-bit counters and an 8-bit override that saturates. Expected
// counts come from the recorded input history: a cycle disagrees when
// fast_q, delayed ALIGN_DLY+1 cycles, differs from ref_q delayed 1 cycle.
module tb_sync_mismatch_monitor;

  logic       clk = 1'b0;
  logic       rst, fast_q, ref_q, start;
  logic [1:0] win_sel;
  logic [2:0] byte_sel;
  logic [7:0] cb, cb8;
  logic       busy, done, sat, busy8, done8, sat8;

  always #5 clk = ~clk;

  sync_mismatch_monitor #(.CNT_W(24), .ALIGN_DLY(2), .WIN_BASE(1024), .WIN_W(23)) dut (
    .clk(clk), .rst(rst), .fast_q(fast_q), .ref_q(ref_q), .start(start),
    .win_sel(win_sel), .byte_sel(byte_sel), .count_byte(cb),
    .busy(busy), .done(done), .sat(sat)
  );

  sync_mismatch_monitor #(.CNT_W(8), .ALIGN_DLY(2), .WIN_BASE(1024), .WIN_W(23)) dut8 (
    .clk(clk), .rst(rst), .fast_q(fast_q), .ref_q(ref_q), .start(start),
    .win_sel(win_sel), .byte_sel(byte_sel), .count_byte(cb8),
    .busy(busy8), .done(done8), .sat(sat8)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Input history, one entry per rising edge.
  bit hf[$];
  bit hr[$];
  always @(posedge clk) begin
    hf.push_back(fast_q);
    hr.push_back(ref_q);
  end

  // Stimulus modes: 0 independent random, 1 ref = fast delayed 2 (fast
  // toggling), 2 constant fast=1 ref=0, 3 ref = random fast delayed 2 with
  // occasional injected disagreements.
  int mode = 0;
  always @(negedge clk) begin
    bit prev;
    prev = (hf.size() >= 2) ? hf[hf.size()-2] : 1'b0;
    case (mode)
      0: begin fast_q = 1'($urandom_range(0, 1)); ref_q = 1'($urandom_range(0, 1)); end
      1: begin fast_q = ~fast_q; ref_q = prev; end
      2: begin fast_q = 1'b1; ref_q = 1'b0; end
      default: begin
        fast_q = 1'($urandom_range(0, 1));
        ref_q  = prev ^ ($urandom_range(0, 9) == 0);
      end
    endcase
  end

  function automatic logic [7:0] exp_byte(input int unsigned sel, input int unsigned mis,
                                          input int unsigned edg, input int unsigned cw,
                                          input bit dn, input bit bz);
    int unsigned mx, m, e;
    bit s;
    mx = (32'd1 << cw) - 1;
    m  = (mis > mx) ? mx : mis;
    e  = (edg > mx) ? mx : edg;
    s  = (mis > mx) || (edg > mx);
    case (sel)
      0: return 8'(m);
      1: return 8'(m >> 8);
      2: return 8'(m >> 16);
      3: return 8'(e);
      4: return 8'(e >> 8);
      5: return 8'(e >> 16);
      6: return {5'b0, s, dn, bz};
      default: return 8'hA5;
    endcase
  endfunction

  // Scoreboard: reads push expectations; the monitor pops one entry each
  // cycle a registered readout becomes valid.
  typedef struct {
    int unsigned sel;
    logic [7:0]  e24;
    logic [7:0]  e8;
  } exp_t;
  exp_t sbq[$];
  bit rd_req = 1'b0;
  bit rd_vld = 1'b0;
  always @(posedge clk) rd_vld <= rd_req;

  always @(negedge clk) begin
    exp_t x;
    if (rd_vld) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got readout with empty queue, required entry");
      end else begin
        x = sbq.pop_front();
        check($sformatf("byte24_sel%0d", x.sel), 32'(cb), 32'(x.e24));
        check($sformatf("byte8_sel%0d", x.sel), 32'(cb8), 32'(x.e8));
      end
    end
  end

  task automatic read_all(input int unsigned mis, input int unsigned edg, input bit dn, input bit bz);
    exp_t x;
    for (int unsigned s = 0; s < 8; s++) begin
      @(negedge clk);
      x.sel = s;
      x.e24 = exp_byte(s, mis, edg, 24, dn, bz);
      x.e8  = exp_byte(s, mis, edg, 8, dn, bz);
      sbq.push_back(x);
      byte_sel = 3'(s);
      rd_req   = 1'b1;
    end
    @(negedge clk);
    rd_req = 1'b0;
    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sbq.size()), 32'd0);
  endtask

  task automatic run(input int m, input logic [1:0] ws, input int restart_at);
    int unsigned s, w, cyc, busy_cnt, mis, edg;
    bit got;
    mode = m;
    repeat (8) @(negedge clk);
    start   = 1'b1;
    win_sel = ws;
    @(posedge clk);
    #1 s = hf.size() - 1;
    w = 1024 << (4 * ws);
    busy_cnt = 0;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < w + 20) begin
      @(negedge clk);
      start = (int'(cyc) == restart_at);
      win_sel = 2'($urandom_range(0, 3));
      cyc++;
      if (busy) busy_cnt++;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    check("done_seen", 32'(got), 32'd1);
    check("busy_cycles", busy_cnt, w);
    check("done8", 32'(done8), 32'd1);
    mis = 0;
    edg = 0;
    for (int unsigned k = s + 1; k <= s + w; k++) begin
      mis += 32'(hf[k-3] ^ hr[k-1]);
      edg += 32'(hr[k-1] ^ hr[k-2]);
    end
    check("sat24", 32'(sat), 32'((mis > 32'hFF_FFFF) || (edg > 32'hFF_FFFF)));
    check("sat8", 32'(sat8), 32'((mis > 255) || (edg > 255)));
    read_all(mis, edg, 1'b1, 1'b0);
  endtask

  task automatic reset_mid_run();
    int unsigned busy_cnt;
    mode = 3;
    repeat (8) @(negedge clk);
    start   = 1'b1;
    win_sel = 2'd0;
    @(negedge clk);
    start = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 500; i++) begin
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    check("busy_before_rst", busy_cnt, 32'd500);
    rst = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sat", 32'(sat), 32'd0);
    check("rst_byte24", 32'(cb), 32'd0);
    check("rst_byte8", 32'(cb8), 32'd0);
    rst = 1'b0;
    read_all(0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; win_sel = 2'd0; byte_sel = 3'd0;
    fast_q = 1'b0; ref_q = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_byte24", 32'(cb), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sat", 32'(sat), 32'd0);
    check("reset_byte8", 32'(cb8), 32'd0);
    rst = 1'b0;
    read_all(0, 0, 1'b0, 1'b0);

    run(1, 2'd0, -1);   // aligned toggling: no mismatches, edge every cycle
    run(2, 2'd1, -1);   // constant mismatch over the 16384-cycle window
    run(2, 2'd0, 300);  // start pulsed mid-run must be ignored
    run(1, 2'd0, -1);   // restart from DONE clears prior counts
    run(0, 2'd0, -1);
    run(3, 2'd0, -1);
    run(3, 2'd0, -1);
    reset_mid_run();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
